// File: rtl/song_pkg.sv
// Shared definitions for the song sequencer: sizes, recorder states and
// the {gates, duration} entry layout used by both recorder and player.
package song_pkg;

  localparam int unsigned DEPTH_DEF = 64;
  localparam int unsigned NOTES_DEF = 8;
  localparam int unsigned DUR_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_FIRST,
    ST_RECORD,
    ST_FLUSH,
    ST_DONE
  } rec_state_t;

  // Entry layout: gates in the MSBs, duration in the LSBs.
  function automatic logic [NOTES_DEF+DUR_W_DEF-1:0] pack_entry(
    input logic [NOTES_DEF-1:0] gates,
    input logic [DUR_W_DEF-1:0] dur
  );
    return {gates, dur};
  endfunction

  function automatic logic [NOTES_DEF-1:0] entry_gates(
    input logic [NOTES_DEF+DUR_W_DEF-1:0] entry
  );
    return entry[NOTES_DEF+DUR_W_DEF-1:DUR_W_DEF];
  endfunction

  function automatic logic [DUR_W_DEF-1:0] entry_dur(
    input logic [NOTES_DEF+DUR_W_DEF-1:0] entry
  );
    return entry[DUR_W_DEF-1:0];
  endfunction

endpackage

// File: rtl/event_ram.sv
// Simple dual-port event store: synchronous write, registered
// read-before-write read port. Only the read register is reset.
module event_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: store on the clock edge when enabled.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port: registered, returns the pre-write contents on a collision.
  always_ff @(posedge clock) begin
    if (reset) rd_data <= '0;
    else       rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/note_event_recorder.sv
// Run-length recorder of the live gate bus: one entry per stretch of
// constant gates, duration counted in 32nd-note ticks.
module note_event_recorder
  import song_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned NOTES = NOTES_DEF,
  parameter int unsigned DUR_W = DUR_W_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     tick,
  input  logic                     start,
  input  logic                     stop,
  input  logic [NOTES-1:0]         note_gates,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [NOTES+DUR_W-1:0]   rd_data,
  output logic [$clog2(DEPTH):0]   event_count,
  output logic                     recording,
  output logic                     full,
  output logic                     done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]      CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]      CNT_ONE  = (AW+1)'(1);
  localparam logic [DUR_W-1:0] DUR_MAX  = '1;
  localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);

  rec_state_t state, state_n;
  logic [NOTES-1:0] cur, cur_n;
  logic [DUR_W-1:0] dur, dur_n;
  logic [AW:0]      count_n;
  logic             full_n, done_n;
  logic             wr_en;
  logic [NOTES+DUR_W-1:0] wr_data;
  logic [AW:0]      count_inc;

  assign count_inc = event_count + CNT_ONE;
  assign recording = (state == ST_WAIT_FIRST) || (state == ST_RECORD);

  // State, pending segment and counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      cur         <= '0;
      dur         <= '0;
      event_count <= '0;
      full        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      cur         <= cur_n;
      dur         <= dur_n;
      event_count <= count_n;
      full        <= full_n;
      done        <= done_n;
    end
  end

  // Next-state and write decision. A tick coinciding with stop is folded
  // into cur/dur first; FLUSH then writes the updated segment.
  always_comb begin
    state_n = state;
    cur_n   = cur;
    dur_n   = dur;
    count_n = event_count;
    full_n  = full;
    done_n  = done;
    wr_en   = 1'b0;
    wr_data = {cur, dur};

    if (start) begin
      state_n = ST_WAIT_FIRST;
      count_n = '0;
      full_n  = 1'b0;
      done_n  = 1'b0;
    end else begin
      case (state)
        ST_IDLE: ;
        ST_WAIT_FIRST: begin
          if (tick && (note_gates != '0)) begin
            cur_n   = note_gates;
            dur_n   = DUR_ONE;
            state_n = stop ? ST_FLUSH : ST_RECORD;
          end else if (stop) begin
            state_n = ST_DONE;
            done_n  = 1'b1;
          end
        end
        ST_RECORD: begin
          if (tick) begin
            if (note_gates == cur) begin
              if (dur != DUR_MAX) begin
                dur_n = dur + DUR_ONE;
              end else begin
                wr_en = 1'b1;
                dur_n = DUR_ONE;
              end
            end else begin
              wr_en = 1'b1;
              cur_n = note_gates;
              dur_n = DUR_ONE;
            end
          end
          if (wr_en) count_n = count_inc;
          if (wr_en && (count_inc == CNT_FULL)) begin
            full_n  = 1'b1;
            done_n  = 1'b1;
            state_n = ST_DONE;
          end else if (stop) begin
            state_n = ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          wr_en   = 1'b1;
          count_n = count_inc;
          full_n  = (count_inc == CNT_FULL);
          done_n  = 1'b1;
          state_n = ST_DONE;
        end
        ST_DONE: ;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  event_ram #(
    .DEPTH(DEPTH),
    .WIDTH(NOTES + DUR_W)
  ) u_event_ram (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (event_count[AW-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_note_event_recorder.sv
// Directed bench for note_event_recorder with hand-computed entries.
module tb_note_event_recorder;

  logic        clock;
  logic        reset;
  logic        tick;
  logic        start;
  logic        stop;
  logic [7:0]  note_gates;
  logic [5:0]  rd_addr;
  logic [15:0] rd_data;
  logic [6:0]  event_count;
  logic        recording;
  logic        full;
  logic        done;

  int errors = 0;
  int checks = 0;

  note_event_recorder #(
    .DEPTH(64),
    .NOTES(8),
    .DUR_W(8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .tick        (tick),
    .start       (start),
    .stop        (stop),
    .note_gates  (note_gates),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .event_count (event_count),
    .recording   (recording),
    .full        (full),
    .done        (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input logic [7:0] g, input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      note_gates = g;
      cyc();
    end
    tick = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // stop, then one more edge for the FLUSH write.
  task automatic pulse_stop_flush();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    cyc();
  endtask

  task automatic read_chk(input string tag, input logic [5:0] a, input logic [15:0] exp);
    rd_addr = a;
    cyc();
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; start = 1'b0; stop = 1'b0;
    note_gates = '0; rd_addr = '0;
    cyc(); cyc();
    chk("reset_rd_data", 32'(rd_data), 32'h0);
    chk("reset_count", 32'(event_count), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    chk("idle_count", 32'(event_count), 32'd0);
    chk("idle_recording", 32'(recording), 32'd0);
    chk("idle_full", 32'(full), 32'd0);
    chk("idle_done", 32'(done), 32'd0);

    // Leading silence dropped, two segments.
    pulse_start();
    chk("t1_recording", 32'(recording), 32'd1);
    ticks(8'h00, 3);
    ticks(8'h01, 4);
    ticks(8'h05, 2);
    chk("t1_count_pre_stop", 32'(event_count), 32'd1);
    pulse_stop_flush();
    chk("t1_count", 32'(event_count), 32'd2);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_recording_off", 32'(recording), 32'd0);
    read_chk("t1_e0", 6'd0, 16'h0104);
    read_chk("t1_e1", 6'd1, 16'h0502);

    // Duration saturation: 300 ticks -> 255 + 45.
    pulse_start();
    chk("t2_count_cleared", 32'(event_count), 32'd0);
    chk("t2_done_cleared", 32'(done), 32'd0);
    ticks(8'h20, 255);
    chk("t2_count_at_max", 32'(event_count), 32'd0);
    ticks(8'h20, 1);
    chk("t2_count_wrap_entry", 32'(event_count), 32'd1);
    ticks(8'h20, 44);
    pulse_stop_flush();
    chk("t2_count", 32'(event_count), 32'd2);
    read_chk("t2_e0", 6'd0, 16'h20FF);
    read_chk("t2_e1", 6'd1, 16'h202D);

    // Fill to DEPTH with alternating gates.
    pulse_start();
    for (int i = 0; i < 64; i++) ticks((i % 2 == 0) ? 8'h01 : 8'h02, 1);
    chk("t3_count_63", 32'(event_count), 32'd63);
    chk("t3_not_full", 32'(full), 32'd0);
    ticks(8'h01, 1);
    chk("t3_count_64", 32'(event_count), 32'd64);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_done", 32'(done), 32'd1);
    for (int i = 0; i < 5; i++) ticks((i % 2 == 0) ? 8'h02 : 8'h01, 1);
    stop = 1'b1; cyc(); stop = 1'b0; cyc();
    chk("t3_count_held", 32'(event_count), 32'd64);
    chk("t3_full_held", 32'(full), 32'd1);
    read_chk("t3_e0", 6'd0, 16'h0101);
    read_chk("t3_e1", 6'd1, 16'h0201);
    read_chk("t3_e62", 6'd62, 16'h0101);
    read_chk("t3_e63", 6'd63, 16'h0201);

    // start together with stop: start wins; then tick+stop same cycle.
    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    chk("t4_start_wins", 32'(recording), 32'd1);
    chk("t4_full_cleared", 32'(full), 32'd0);
    ticks(8'h01, 3);
    tick = 1'b1; note_gates = 8'h04; stop = 1'b1;
    cyc();
    tick = 1'b0; stop = 1'b0;
    chk("t4_count_after_tick", 32'(event_count), 32'd1);
    chk("t4_not_done_yet", 32'(done), 32'd0);
    cyc();
    chk("t4_count", 32'(event_count), 32'd2);
    chk("t4_done", 32'(done), 32'd1);
    read_chk("t4_e0", 6'd0, 16'h0103);
    read_chk("t4_e1", 6'd1, 16'h0401);

    // Reset mid-recording, then a fresh single-entry recording.
    pulse_start();
    ticks(8'h08, 2);
    ticks(8'h10, 1);
    reset = 1'b1;
    cyc();
    chk("t5_rst_count", 32'(event_count), 32'd0);
    chk("t5_rst_recording", 32'(recording), 32'd0);
    chk("t5_rst_full", 32'(full), 32'd0);
    chk("t5_rst_done", 32'(done), 32'd0);
    chk("t5_rst_rd_data", 32'(rd_data), 32'h0);
    reset = 1'b0;
    cyc();
    chk("t5_idle_after_reset", 32'(recording), 32'd0);
    pulse_start();
    ticks(8'h80, 1);
    pulse_stop_flush();
    chk("t5_count", 32'(event_count), 32'd1);
    chk("t5_done", 32'(done), 32'd1);
    read_chk("t5_e0", 6'd0, 16'h8001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
